// File: rtl/rubik_wcmd_arb_pkg.sv
// ============================================================================
// rubik_wcmd_arb_pkg : shared state type and helpers for the wcmd arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package rubik_wcmd_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   localparam int MAX_BURST_CNT = 255;

   // Index width for a requester pointer; never narrower than one bit.
   function automatic int RR_PTR_W(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rubik_wcmd_rr_pick.sv
// ============================================================================
// rubik_wcmd_rr_pick : combinational rotate-priority picker starting at ptr
// Revision: 1.0
// ============================================================================
`default_nettype none

module rubik_wcmd_rr_pick
   import rubik_wcmd_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int PW      = RR_PTR_W(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] elig,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PW-1:0]      index,
   output logic               any
);

   localparam logic [PW:0] NUM_W = (PW+1)'(NUM_REQ);

   logic [PW:0]   pos;
   logic [PW-1:0] idx;

   // ptr is always below NUM_REQ, so one conditional subtract gives the modulo.
   always_comb begin
      grant = '0;
      index = '0;
      any   = 1'b0;
      pos   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = {1'b0, ptr} + (PW+1)'(k);
         if (pos >= NUM_W) begin
            pos = pos - NUM_W;
         end
         idx = pos[PW-1:0];
         if (!any && elig[idx]) begin
            any   = 1'b1;
            index = idx;
         end
      end
      grant[index] = any;
   end

endmodule

`default_nettype wire

// File: rtl/rubik_wcmd_arb.sv
// ============================================================================
// rubik_wcmd_arb : burst-locked round-robin arbiter feeding the RUBIK wcmd FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module rubik_wcmd_arb
   import rubik_wcmd_arb_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int DW        = 11,
   parameter int MAX_BURST = 64
)(
   input  logic                            nvdla_core_clk,
   input  logic                            nvdla_core_rstn,
   input  logic [NUM_REQ-1:0]              req_pvld,
   output logic [NUM_REQ-1:0]              req_prdy,
   input  logic [NUM_REQ*DW-1:0]           req_pd,
   input  logic [NUM_REQ-1:0]              req_last,
   input  logic [NUM_REQ-1:0]              cfg_req_en,
   output logic                            wcmd_pvld,
   input  logic                            wcmd_prdy,
   output logic [DW-1:0]                   wcmd_pd,
   output logic                            arb_idle,
   output logic [RR_PTR_W(NUM_REQ)-1:0]    arb_owner,
   output logic                            err_burst_long,
   input  logic                            err_clr
);

   localparam int            PW          = RR_PTR_W(NUM_REQ);
   localparam logic [PW-1:0] LAST_IDX    = PW'(NUM_REQ - 1);
   localparam logic [8:0]    BURST_LIMIT = 9'(MAX_BURST);
   localparam logic [8:0]    CNT_SAT     = 9'(MAX_BURST_CNT);

   arb_state_e          state;
   arb_state_e          state_nxt;
   logic [PW-1:0]       rr_ptr;
   logic [PW-1:0]       rr_ptr_nxt;
   logic [PW-1:0]       owner_nxt;
   logic [PW-1:0]       pick_index;
   logic [PW-1:0]       sel_idx;
   logic [7:0]          beat_cnt;
   logic [7:0]          beat_cnt_nxt;
   logic [8:0]          beat_sum;
   logic                err_nxt;
   logic                slot_free;
   logic                accept;
   logic                sel_last;
   logic                pick_any;
   logic [NUM_REQ-1:0]  pick_elig;
   logic [NUM_REQ-1:0]  pick_grant;
   logic [NUM_REQ-1:0]  owner_grant;
   logic [NUM_REQ-1:0]  grant;
   logic [DW-1:0]       sel_pd;

   assign slot_free = !wcmd_pvld || wcmd_prdy;
   assign pick_elig = req_pvld & cfg_req_en;

   rubik_wcmd_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_pick (
      .elig  (pick_elig),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .index (pick_index),
      .any   (pick_any)
   );

   always_comb begin
      owner_grant            = '0;
      owner_grant[arb_owner] = 1'b1;
   end

   // A locked owner keeps its grant even if its enable bit is dropped mid-burst.
   assign grant    = (state == IDLE) ? pick_grant : owner_grant;
   assign sel_idx  = (state == IDLE) ? pick_index : arb_owner;
   assign req_prdy = slot_free ? grant : '0;
   assign accept   = slot_free && ((state == IDLE) ? pick_any : req_pvld[arb_owner]);
   assign sel_last = req_last[sel_idx];
   assign beat_sum = {1'b0, beat_cnt} + 9'd1;

   always_comb begin
      sel_pd = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (PW'(i) == sel_idx) begin
            sel_pd = req_pd[i*DW +: DW];
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      owner_nxt    = arb_owner;
      beat_cnt_nxt = beat_cnt;
      err_nxt      = err_burst_long && !err_clr;
      if (accept) begin
         owner_nxt = sel_idx;
         if (sel_last) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = (sel_idx == LAST_IDX) ? '0 : sel_idx + PW'(1);
            beat_cnt_nxt = '0;
         end else begin
            state_nxt = LOCK;
            if (state == IDLE) begin
               beat_cnt_nxt = 8'd1;
            end else begin
               beat_cnt_nxt = (beat_sum > CNT_SAT) ? 8'(MAX_BURST_CNT) : beat_sum[7:0];
            end
         end
         // Only a locked beat can push the count past the limit; setting wins over err_clr.
         if ((state == LOCK) && (beat_sum > BURST_LIMIT)) begin
            err_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         arb_owner      <= '0;
         beat_cnt       <= '0;
         err_burst_long <= 1'b0;
         wcmd_pvld      <= 1'b0;
      end else begin
         state          <= state_nxt;
         rr_ptr         <= rr_ptr_nxt;
         arb_owner      <= owner_nxt;
         beat_cnt       <= beat_cnt_nxt;
         err_burst_long <= err_nxt;
         if (slot_free) begin
            wcmd_pvld <= accept;
         end
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (accept) begin
         wcmd_pd <= sel_pd;
      end
   end

   assign arb_idle = (state == IDLE) && !wcmd_pvld;

endmodule

`default_nettype wire
